// File: rtl/arm_pkg.sv
// Shared types and helpers for the memory-stage SRAM controller.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } sram_op_t;

  localparam int DEFAULT_BASE_ADDR = 1024;

  // Number of SRAM beats that make up one CPU word.
  function automatic int beats(input int cpu_dw, input int sram_dw);
    return cpu_dw / sram_dw;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Per-beat wait-state counter: counts 0..WAIT_STATES and flags the last cycle of a beat.
module wait_counter
  import arm_pkg::*;
#(
  parameter int WAIT_STATES = 5,
  parameter int W           = cnt_width(WAIT_STATES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == W'(WAIT_STATES));

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: splits each CPU load/store into BEATS narrow SRAM beats with wait states,
// holding ready low until the access completes.
module mem_sram_ctrl
  import arm_pkg::*;
#(
  parameter int CPU_DW      = 32,
  parameter int SRAM_DW     = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 5,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [31:0]        address,
  input  logic [CPU_DW-1:0]  write_data,
  output logic [CPU_DW-1:0]  read_data,
  output logic               ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  localparam int BEATS  = beats(CPU_DW, SRAM_DW);
  localparam int BEAT_W = cnt_width(BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (SRAM_DW <= 0 || CPU_DW < SRAM_DW || (CPU_DW % SRAM_DW) != 0) begin : g_bad_width
    $error("mem_sram_ctrl: CPU_DW must be a positive integer multiple of SRAM_DW");
  end

  sram_state_t        state_q, state_d;
  sram_op_t           op_q, op_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [CPU_DW-1:0]  wdata_q, wdata_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BEAT_W-1:0]  beat_nxt;
  logic [CPU_DW-1:0]  read_data_q, read_data_d;
  logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               req;
  logic               wait_clr, wait_en, wait_last;

  // SRAM word address of a given beat of a CPU word.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] word,
                                                 input logic [BEAT_W-1:0] beat);
    return word * ADDR_W'(BEATS) + ADDR_W'(beat);
  endfunction

  assign req      = read_en | write_en;
  assign beat_nxt = beat_q + 1'b1;

  wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (wait_clr),
    .en   (wait_en),
    .last (wait_last)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = oe_q;
    we_n_d      = we_n_q;
    wait_clr    = 1'b1;
    wait_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          // Pad outputs for beat 0 are loaded on this edge so they are valid from the first ACCESS cycle.
          op_d        = write_en ? OP_WRITE : OP_READ;
          word_d      = ADDR_W'((address - 32'(BASE_ADDR)) >> 2);
          wdata_d     = write_data;
          beat_d      = '0;
          sram_addr_d = map_addr(word_d, '0);
          dq_out_d    = write_data[SRAM_DW-1:0];
          oe_d        = write_en;
          we_n_d      = ~write_en;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        wait_clr = 1'b0;
        wait_en  = 1'b1;
        if (wait_last) begin
          if (op_q == OP_READ) begin
            read_data_d[beat_q*SRAM_DW +: SRAM_DW] = sram_dq_in;
          end
          if (beat_q == LAST_BEAT) begin
            oe_d    = 1'b0;
            we_n_d  = 1'b1;
            state_d = DONE;
          end else begin
            beat_d      = beat_nxt;
            sram_addr_d = map_addr(word_q, beat_nxt);
            if (op_q == OP_WRITE) begin
              dq_out_d = wdata_q[beat_nxt*SRAM_DW +: SRAM_DW];
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset too, because read_data and the pad outputs must come out of reset at defined values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      word_q      <= '0;
      wdata_q     <= '0;
      beat_q      <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // ready stays combinational so a new request freezes the pipeline in the very cycle it appears.
  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: default configuration against a cycle-level transaction model,
// plus a single-beat zero-wait configuration with hand-computed expectations.
module tb_mem_sram_ctrl;

  localparam int WS    = 5;
  localparam int BEATS = 2;
  localparam int L0    = BEATS * (WS + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        re0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wd0 = '0, rd0;
  logic        rdy0, oe0, wen0;
  logic [17:0] sa0;
  logic [15:0] dqo0, dqi0;

  // Single-beat, zero-wait instance
  logic        re1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wd1 = '0, rd1;
  logic        rdy1, oe1, wen1;
  logic [17:0] sa1;
  logic [31:0] dqo1, dqi1;

  mem_sram_ctrl u_dut0 (
    .clk(clk), .rst(rst), .read_en(re0), .write_en(we0), .address(addr0),
    .write_data(wd0), .read_data(rd0), .ready(rdy0), .sram_addr(sa0),
    .sram_dq_out(dqo0), .sram_dq_oe(oe0), .sram_dq_in(dqi0), .sram_we_n(wen0)
  );

  mem_sram_ctrl #(
    .CPU_DW(32), .SRAM_DW(32), .ADDR_W(18), .WAIT_STATES(0), .BASE_ADDR(1024)
  ) u_dut1 (
    .clk(clk), .rst(rst), .read_en(re1), .write_en(we1), .address(addr1),
    .write_data(wd1), .read_data(rd1), .ready(rdy1), .sram_addr(sa1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1), .sram_we_n(wen1)
  );

  // Asynchronous SRAM pad models with a known fill pattern
  logic [15:0] mem0 [256];
  logic [31:0] mem1 [256];

  function automatic logic [15:0] pat16(input int i);
    return 16'(32'hA000 + i * 7);
  endfunction

  function automatic logic [31:0] pat32(input int i);
    return 32'h5000_0000 + 32'(i * 13);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = pat16(i);
      mem1[i] = pat32(i);
    end
  end

  always @(posedge clk) begin
    if (!wen0) mem0[sa0[7:0]] <= dqo0;
  end

  assign dqi0 = mem0[sa0[7:0]];
  assign dqi1 = mem1[sa1[7:0]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the default instance
  logic [31:0] exp_mem [int];
  int          phase = -1;
  bit          m_wr;
  int          m_word;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;

  function automatic logic [31:0] exp_read(input int w);
    if (exp_mem.exists(w)) return exp_mem[w];
    return {pat16(2 * w + 1), pat16(2 * w)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase   = -1;
        m_rdata = '0;
        check("rst_ready", rdy0, !(re0 | we0));
        check("rst_we_n",  wen0, 1);
        check("rst_oe",    oe0, 0);
        check("rst_addr",  sa0, 0);
        check("rst_dq",    dqo0, 0);
        check("rst_rdata", rd0, 0);
      end else begin
        bit in_acc;
        int beat;
        if (phase < 0 && (re0 || we0)) begin
          phase   = 0;
          m_wr    = we0;
          m_word  = (int'(addr0) - 1024) >>> 2;
          m_wdata = wd0;
        end
        in_acc = (phase >= 1) && (phase < L0);
        check("m_ready", rdy0, (phase < 0) || (phase == L0));
        check("m_we_n",  wen0, !(in_acc && m_wr));
        check("m_oe",    oe0,  in_acc && m_wr);
        if (in_acc) begin
          beat = (phase - 1) / (WS + 1);
          check("m_addr", sa0, 18'(m_word * BEATS + beat));
          if (m_wr) check("m_dq", dqo0, m_wdata[16*beat +: 16]);
        end
        if (phase == L0) begin
          if (m_wr) exp_mem[m_word] = m_wdata;
          else      m_rdata = exp_read(m_word);
        end
        if (!(in_acc && !m_wr)) check("m_rdata", rd0, m_rdata);
        if (phase == L0)     phase = -1;
        else if (phase >= 0) phase++;
      end
    end
  end

  // Per-transaction observations used for literal checks
  int          s_ready_low, s_we_low;
  logic [17:0] s_addr_k1, s_addr_k7;
  logic [15:0] s_dq_k1, s_dq_k7;
  logic [31:0] s_rdata_done;
  logic        s_ready_done;

  // Holds the request over cycles 0..L0 (the CPU freezes until DONE), then drops it.
  task automatic observe_txn();
    s_ready_low = 0;
    s_we_low    = 0;
    for (int k = 0; k <= L0; k++) begin
      @(negedge clk);
      if (!rdy0) s_ready_low++;
      if (!wen0) s_we_low++;
      if (k == 1) begin s_addr_k1 = sa0; s_dq_k1 = dqo0; end
      if (k == 7) begin s_addr_k7 = sa0; s_dq_k7 = dqo0; end
      if (k == L0) begin s_ready_done = rdy0; s_rdata_done = rd0; end
    end
    @(posedge clk);
    #1;
    re0 = 1'b0;
    we0 = 1'b0;
  endtask

  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    re0   = r;
    we0   = w;
    addr0 = a;
    wd0   = d;
    observe_txn();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_ready", rdy0, 1);
    check("idle_we_n",  wen0, 1);
    check("idle_oe",    oe0, 0);
    check("idle_rdata", rd0, 0);
    @(posedge clk);
    #1;

    txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("wr_addr_b0",   s_addr_k1, 18'd2);
    check("wr_dq_b0",     s_dq_k1, 16'hBEEF);
    check("wr_addr_b1",   s_addr_k7, 18'd3);
    check("wr_dq_b1",     s_dq_k7, 16'hDEAD);
    check("wr_we_low",    s_we_low, 12);
    check("wr_ready_low", s_ready_low, 13);
    check("wr_ready_done", s_ready_done, 1);

    txn(1'b1, 1'b0, 32'd1028, 32'h0);
    check("rd_data",      s_rdata_done, 32'hDEADBEEF);
    check("rd_we_low",    s_we_low, 0);
    check("rd_ready_low", s_ready_low, 13);

    txn(1'b1, 1'b1, 32'd1032, 32'h12345678);
    check("both_we_low",  s_we_low, 12);
    check("both_addr_b0", s_addr_k1, 18'd4);
    check("both_dq_b0",   s_dq_k1, 16'h5678);
    check("both_rdata",   s_rdata_done, 32'hDEADBEEF);

    txn(1'b1, 1'b0, 32'd1032, 32'h0);
    check("rd2_data", s_rdata_done, 32'h12345678);

    txn(1'b1, 1'b0, 32'd1040, 32'h0);
    check("rd_fill_data", s_rdata_done, 32'hA03FA038);

    // Reset in cycle 4 of a write, request held through and after reset
    we0 = 1'b1; re0 = 1'b0; addr0 = 32'd1100; wd0 = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_we_n", wen0, 0);
    #1 rst = 1'b0;
    #1;
    check("abort_we_n",  wen0, 1);
    check("abort_oe",    oe0, 0);
    check("abort_ready", rdy0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    observe_txn();
    check("fresh_addr_b0",   s_addr_k1, 18'd38);
    check("fresh_dq_b0",     s_dq_k1, 16'hF00D);
    check("fresh_ready_low", s_ready_low, 13);

    txn(1'b1, 1'b0, 32'd1100, 32'h0);
    check("fresh_rd_data", s_rdata_done, 32'hCAFEF00D);

    // Single-beat zero-wait instance with a back-to-back read
    re1 = 1'b1; addr1 = 32'd1024;
    @(negedge clk); check("z_k0_ready", rdy1, 0);
    @(negedge clk); check("z_k1_ready", rdy1, 0);
                    check("z_k1_addr", sa1, 18'd0);
                    check("z_k1_we_n", wen1, 1);
    @(negedge clk); check("z_done_ready", rdy1, 1);
                    check("z_done_rdata", rd1, 32'h50000000);
    @(posedge clk);
    #1 addr1 = 32'd1028;
    @(negedge clk); check("b2b_k0_ready", rdy1, 0);
    @(negedge clk); check("b2b_k1_addr", sa1, 18'd1);
                    check("b2b_k1_oe", oe1, 0);
    @(negedge clk); check("b2b_done_ready", rdy1, 1);
                    check("b2b_done_rdata", rd1, 32'h5000000D);
    @(posedge clk);
    #1 re1 = 1'b0;
    @(negedge clk); check("z_idle_ready", rdy1, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
